// File: rtl/lsu_mem_port_pkg.sv
// Shared types and helpers for the LSU memory port: size encodings, FSM states,
// and alignment/byte-enable decode used at issue time.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

package lsu_mem_port_pkg;

    localparam int LSU_DATA_W = `SIZE_DATA;
    localparam int LSU_TAG_W  = 6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_e;

    // Size 11 has no legal encoding, so it always reports misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational so cache fill paths can reuse it.
module lsu_load_align
    import lsu_mem_port_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        result = rdata;
        case (size)
            SZ_BYTE: result = {{(DATA_W-8){sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = {{(DATA_W-16){sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: AGU issue -> req/gnt/rvalid memory access ->
// valid/ready response to writeback. Misaligned accesses respond without memory traffic.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int TAG_W  = LSU_TAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              resp_misalign_o
);

    lsu_state_e        state, state_nxt;
    logic [1:0]        off_q, size_q;
    logic              sext_q;
    logic              issue_mis;
    logic [DATA_W-1:0] wdata_steer;
    logic [DATA_W-1:0] ld_res;

    assign issue_mis = is_misaligned(size_i, addr_i[1:0]);

    // Narrow stores are replicated across lanes; byte enables select the live one.
    always_comb begin
        wdata_steer = wdata_i;
        case (size_i)
            SZ_BYTE: wdata_steer = {(DATA_W/8){wdata_i[7:0]}};
            SZ_HALF: wdata_steer = {(DATA_W/16){wdata_i[15:0]}};
            default: wdata_steer = wdata_i;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        issue_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        resp_valid_o  = 1'b0;
        case (state)
            S_IDLE: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i) state_nxt = issue_mis ? S_RESP : S_REQ;
            end
            S_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_nxt = mem_we_o ? S_RESP : S_WAIT_R;
            end
            S_WAIT_R: if (mem_rvalid_i) state_nxt = S_RESP;
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q           <= '0;
            size_q          <= '0;
            sext_q          <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_be_o        <= '0;
            mem_wdata_o     <= '0;
            resp_data_o     <= '0;
            resp_tag_o      <= '0;
            resp_misalign_o <= 1'b0;
        end else if (state == S_IDLE && issue_valid_i) begin
            off_q           <= addr_i[1:0];
            size_q          <= size_i;
            sext_q          <= sign_ext_i;
            mem_we_o        <= is_store_i;
            mem_addr_o      <= {addr_i[DATA_W-1:2], 2'b00};
            mem_be_o        <= byte_en(size_i, addr_i[1:0]);
            mem_wdata_o     <= wdata_steer;
            resp_data_o     <= '0;
            resp_tag_o      <= tag_i;
            resp_misalign_o <= issue_mis;
        end else if (state == S_WAIT_R && mem_rvalid_i) begin
            resp_data_o <= ld_res;
        end
    end

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata    (mem_rdata_i),
        .off      (off_q),
        .size     (size_q),
        .sign_ext (sext_q),
        .result   (ld_res)
    );

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store memory port. It consumes the effective address produced by the address generation stage (base + sign-extended 16-bit immediate) and performs the data-memory access with a request/grant/rvalid handshake. It returns aligned, sign- or zero-extended load data, or store completion, to writeback with a valid/ready handshake. Single outstanding access; sits between the AGU output latch and the data-memory interface.

Parameters:
DATA_W, 32, data/address width; equals `SIZE_DATA.
TAG_W, 6, instruction tag width carried through to the response.

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  reset, asynchronous, active-low
issue_valid_i  in  1  access request from AGU stage
issue_ready_o  out  1  block can accept a request
addr_i  in  DATA_W  effective byte address from AGU
wdata_i  in  DATA_W  store data, right-justified
is_store_i  in  1  1 = store, 0 = load
size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
sign_ext_i  in  1  load sign-extend (1) or zero-extend (0)
tag_i  in  TAG_W  instruction tag
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted the request this cycle
mem_we_o  out  1  write enable
mem_addr_o  out  DATA_W  word-aligned address (bits [1:0] = 0)
mem_be_o  out  4  byte enables
mem_wdata_o  out  DATA_W  lane-steered store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DATA_W  read word
resp_valid_o  out  1  response valid
resp_ready_i  in  1  writeback accepts response
resp_data_o  out  DATA_W  load result; 0 for stores and faults
resp_tag_o  out  TAG_W  tag of the completed access
resp_misalign_o  out  1  access faulted on alignment

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0 except issue_ready_o = 1. A reset during any state aborts the access and deasserts mem_req_o immediately. No response is produced for the aborted access.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- issue_ready_o = (state == IDLE). There is no back-to-back accept from RESP.
- IDLE: on issue_valid_i, capture all issue inputs.
  - Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0, or size 11): go to RESP with misalign = 1, data 0, and no memory traffic.
  - Otherwise go to REQ.
- REQ: mem_req_o = 1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from registers and stay stable until grant.
  - On mem_gnt_i: a store goes to RESP; a load goes to WAIT_R.
  - mem_req_o drops in the cycle after grant.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data is replicated to its lanes: byte data is copied into all 4 lanes, half data into both halves.
- WAIT_R: on mem_rvalid_i, select the byte/half lane by addr[1:0], extend it to DATA_W, register it into resp_data_o, then go to RESP.
  - mem_rvalid_i is valid no earlier than the cycle after grant.
  - rvalid in the grant cycle or in any other state is ignored.
- RESP: resp_valid_o = 1 with data, tag and misalign held stable. On resp_ready_i go to IDLE and clear resp_valid_o in the next cycle.
- Minimum latencies (zero-wait memory, issue accepted at cycle 0):
  - store: req at cycle 1, gnt at cycle 1, resp_valid at cycle 2.
  - load: rvalid at cycle 2, resp_valid at cycle 3.
  - misaligned: resp_valid at cycle 1.
- Address arithmetic is never done here. addr_i is used as given, and a 32-bit wrap in the AGU is legal.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the DATA_W/TAG_W defaults tied to `SIZE_DATA.
- One combinational sub-module, lsu_load_align: takes rdata, addr[1:0], size and sign_ext, and produces the extended result. It is shared with future cache fill paths.
- Store lane steering stays inline.

Test Plan:
- Word load, addr 0x1000, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> mem_addr 0x1000, be 1111, resp_data 0xDEADBEEF at cycle 3, correct tag.
- Signed byte load, addr 0x1003, rdata 0x80FF_0000 -> be 1000, resp_data 0xFFFFFF80. The same access with sign_ext = 0 -> 0x00000080.
- Half store, addr 0x2002, wdata 0x0000ABCD, gnt delayed 3 cycles -> req and addr held stable, be 1100, mem_wdata 0xABCDABCD, resp_valid the cycle after gnt, resp_data 0.
- Word load at addr 0x3001 -> no mem_req, resp_misalign = 1 at cycle 1, issue_ready low until the response is accepted.
- resp_ready held low for 5 cycles -> resp outputs stable, no new issue accepted. Spurious rvalid during RESP is ignored.
- reset_n asserted while in WAIT_R -> mem_req and resp_valid go to 0 asynchronously, issue_ready = 1 after release, and a late rvalid produces no response.
